bg_trim_filter: RTL and testbench

- Consumes the trim codes produced by the bandgap SAR trim controller.
- Captures one code per `valid` pulse and averages it over a window of samples.
- Detects when successive window averages have settled, and flags a stalled trim loop.
- Provides the filtered 12-bit trim code, an update strobe and a lock flag to the top-level / analog trim register.

---
 rtl/bg_trim_filter.sv | 170 +++++++++++++++++
 tb/tb_bg_trim_filter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bg_trim_filter.sv
// Bandgap trim-code filter: captures one SAR trim code per valid_in rising edge, averages
// 2^LOG2_AVG codes per window, tracks settling between windows and flags a stalled trim loop.
module bg_trim_filter #(
  parameter int unsigned LOG2_AVG = 2,
  parameter int unsigned LOCK_TOL = 1,
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned TIMEOUT  = 1023,
  parameter int unsigned CNT_W    = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pwrup,
  input  logic        valid_in,
  input  logic [7:0]  idac_coarse,
  input  logic [7:0]  idac_fine,
  output logic [11:0] trim_code,
  output logic        trim_strobe,
  output logic        locked,
  output logic        stall,
  output logic [2:0]  win_count
);

  localparam int unsigned AccW = 12 + LOG2_AVG;
  localparam int unsigned NW   = LOG2_AVG + 1;

  localparam logic [NW-1:0]    WinLen     = NW'(1 << LOG2_AVG);
  localparam logic [AccW-1:0]  RoundHalf  = AccW'(1 << (LOG2_AVG - 1));
  localparam logic [2:0]       LockCntVal = 3'(LOCK_CNT);
  localparam logic [11:0]      LockTolVal = 12'(LOCK_TOL);
  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StAcc, StUpdate} state_e;

  state_e           r_state, w_state_d;
  logic             r_valid_d;
  logic [AccW-1:0]  r_acc, w_acc_d;
  logic [NW-1:0]    r_n, w_n_d;
  logic [CNT_W-1:0] r_wdog, w_wdog_d;
  logic             r_stall, w_stall_d;
  logic             r_locked, w_locked_d;
  logic [2:0]       r_run, w_run_d;
  logic [11:0]      r_prev, w_prev_d;
  logic             r_have_prev, w_have_prev_d;
  logic [11:0]      r_code, w_code_d;
  logic             r_strobe, w_strobe_d;
  logic [2:0]       r_win, w_win_d;

  logic [11:0]      w_code_in;
  logic             w_capture;
  logic [AccW-1:0]  w_acc_rnd;
  logic [11:0]      w_avg;
  logic [11:0]      w_diff;

  assign w_code_in = {idac_coarse, idac_fine[7:4]};
  // Only a rising edge of the valid level, seen while accumulating, takes a sample.
  assign w_capture = valid_in & ~r_valid_d & (r_state == StAcc);
  assign w_acc_rnd = r_acc + RoundHalf;
  assign w_avg     = w_acc_rnd[AccW-1:LOG2_AVG];
  assign w_diff    = (w_avg >= r_prev) ? (w_avg - r_prev) : (r_prev - w_avg);

  // Next-state and datapath update; pwrup low overrides every FSM action.
  always_comb begin
    w_state_d     = r_state;
    w_acc_d       = r_acc;
    w_n_d         = r_n;
    w_wdog_d      = r_wdog;
    w_stall_d     = r_stall;
    w_locked_d    = r_locked;
    w_run_d       = r_run;
    w_prev_d      = r_prev;
    w_have_prev_d = r_have_prev;
    w_code_d      = r_code;
    w_strobe_d    = 1'b0;
    w_win_d       = r_win;

    if (!pwrup) begin
      w_state_d     = StIdle;
      w_acc_d       = '0;
      w_n_d         = '0;
      w_wdog_d      = '0;
      w_stall_d     = 1'b0;
      w_locked_d    = 1'b0;
      w_run_d       = '0;
      w_prev_d      = '0;
      w_have_prev_d = 1'b0;
      w_code_d      = '0;
      w_win_d       = '0;
    end else begin
      unique case (r_state)
        StIdle: w_state_d = StAcc;
        StAcc: begin
          if (w_capture) begin
            w_acc_d   = r_acc + AccW'(w_code_in);
            w_n_d     = r_n + 1'b1;
            w_wdog_d  = '0;
            w_stall_d = 1'b0;
            if (w_n_d == WinLen) w_state_d = StUpdate;
          end else begin
            if (r_wdog < TimeoutVal) w_wdog_d = r_wdog + 1'b1;
            if (w_wdog_d == TimeoutVal) begin
              w_stall_d  = 1'b1;
              w_locked_d = 1'b0;
              w_run_d    = '0;
            end
          end
        end
        StUpdate: begin
          w_code_d   = w_avg;
          w_strobe_d = 1'b1;
          if (r_win != 3'd7) w_win_d = r_win + 1'b1;
          // The first window after power-up has nothing to compare against.
          if (!r_have_prev) begin
            w_run_d = '0;
          end else if (w_diff <= LockTolVal) begin
            if (r_run != LockCntVal) w_run_d = r_run + 1'b1;
          end else begin
            w_run_d = '0;
          end
          w_locked_d    = (w_run_d == LockCntVal);
          w_prev_d      = w_avg;
          w_have_prev_d = 1'b1;
          w_acc_d       = '0;
          w_n_d         = '0;
          w_state_d     = StAcc;
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  // State register; valid_d tracks valid_in unconditionally so edges outside StAcc are lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_valid_d   <= 1'b0;
      r_acc       <= '0;
      r_n         <= '0;
      r_wdog      <= '0;
      r_stall     <= 1'b0;
      r_locked    <= 1'b0;
      r_run       <= '0;
      r_prev      <= '0;
      r_have_prev <= 1'b0;
      r_code      <= '0;
      r_strobe    <= 1'b0;
      r_win       <= '0;
    end else begin
      r_state     <= w_state_d;
      r_valid_d   <= valid_in;
      r_acc       <= w_acc_d;
      r_n         <= w_n_d;
      r_wdog      <= w_wdog_d;
      r_stall     <= w_stall_d;
      r_locked    <= w_locked_d;
      r_run       <= w_run_d;
      r_prev      <= w_prev_d;
      r_have_prev <= w_have_prev_d;
      r_code      <= w_code_d;
      r_strobe    <= w_strobe_d;
      r_win       <= w_win_d;
    end
  end

  assign trim_code   = r_code;
  assign trim_strobe = r_strobe;
  assign locked      = r_locked;
  assign stall       = r_stall;
  assign win_count   = r_win;

endmodule

// File: tb/tb_bg_trim_filter.sv
// Directed bench for bg_trim_filter: expected window results are queued when a window is
// driven and compared whenever the DUT strobes.
module tb_bg_trim_filter;

  logic        clk;
  logic        reset_n;
  logic        pwrup;
  logic        valid_in;
  logic [7:0]  idac_coarse;
  logic [7:0]  idac_fine;
  logic [11:0] trim_code;
  logic        trim_strobe;
  logic        locked;
  logic        stall;
  logic [2:0]  win_count;

  bg_trim_filter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pwrup       (pwrup),
    .valid_in    (valid_in),
    .idac_coarse (idac_coarse),
    .idac_fine   (idac_fine),
    .trim_code   (trim_code),
    .trim_strobe (trim_strobe),
    .locked      (locked),
    .stall       (stall),
    .win_count   (win_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] code;
    logic [2:0]  win;
    logic        lock;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;
  int strobes  = 0;

  // Reference model of the window/lock bookkeeping.
  logic [11:0] m_prev;
  logic        m_have;
  int          m_run;
  int          m_win;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_prev = '0;
    m_have = 1'b0;
    m_run  = 0;
    m_win  = 0;
  endtask

  task automatic expect_window(input int sum);
    exp_t e;
    logic [11:0] avg;
    int diff;
    avg  = 12'((sum + 2) >> 2);
    diff = (int'(avg) > int'(m_prev)) ? int'(avg) - int'(m_prev) : int'(m_prev) - int'(avg);
    if (!m_have) m_run = 0;
    else if (diff <= 1) m_run = (m_run < 3) ? m_run + 1 : 3;
    else m_run = 0;
    m_win  = (m_win < 7) ? m_win + 1 : 7;
    m_have = 1'b1;
    m_prev = avg;
    e.code = avg;
    e.win  = 3'(m_win);
    e.lock = (m_run == 3);
    sb.push_back(e);
  endtask

  // One clock step; any strobe is checked against the head of the scoreboard.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (trim_strobe === 1'b1) begin
      strobes++;
      chk("unexpected_strobe", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("trim_code", 32'(trim_code), 32'(e.code));
        chk("win_count", 32'(win_count), 32'(e.win));
        chk("locked", 32'(locked), 32'(e.lock));
      end
    end
  endtask

  task automatic set_code(input logic [11:0] c);
    idac_coarse = c[11:4];
    idac_fine   = {c[3:0], 4'hA};  // low nibble must be ignored
  endtask

  task automatic pulse(input logic [11:0] c);
    set_code(c);
    valid_in = 1'b1;
    tick();
    tick();
    valid_in = 1'b0;
    repeat (6) tick();
  endtask

  task automatic window4(input logic [11:0] a, input logic [11:0] b,
                         input logic [11:0] c, input logic [11:0] d);
    expect_window(int'(a) + int'(b) + int'(c) + int'(d));
    pulse(a);
    pulse(b);
    pulse(c);
    pulse(d);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_code"}, 32'(trim_code), 32'h0);
    chk({tag, "_strobe"}, 32'(trim_strobe), 32'h0);
    chk({tag, "_locked"}, 32'(locked), 32'h0);
    chk({tag, "_stall"}, 32'(stall), 32'h0);
    chk({tag, "_win"}, 32'(win_count), 32'h0);
  endtask

  initial begin
    int s0;
    model_clear();
    reset_n  = 1'b0;
    pwrup    = 1'b0;
    valid_in = 1'b0;
    set_code(12'h000);
    repeat (3) @(negedge clk);
    check_cleared("reset");

    // Idle watchdog: stall appears after TIMEOUT non-capture cycles in ACC.
    reset_n = 1'b1;
    pwrup   = 1'b1;
    repeat (1023) tick();
    chk("stall_before_timeout", 32'(stall), 32'h0);
    chk("code_idle", 32'(trim_code), 32'h0);
    tick();
    chk("stall_at_timeout", 32'(stall), 32'h1);
    set_code(12'h805);
    valid_in = 1'b1;
    tick();
    chk("stall_cleared", 32'(stall), 32'h0);
    valid_in = 1'b0;
    repeat (6) tick();

    // Drop the partial window and start a fresh power-up.
    pwrup = 1'b0;
    tick();
    check_cleared("pwrdn1");
    model_clear();
    pwrup = 1'b1;
    tick();

    // Basic window with strobe timing check on the last capture.
    expect_window(4 * 'h805);
    pulse(12'h805);
    pulse(12'h805);
    pulse(12'h805);
    s0 = strobes;
    set_code(12'h805);
    valid_in = 1'b1;
    tick();
    chk("strobe_not_early", 32'(strobes), 32'(s0));
    tick();
    chk("strobe_one_after", 32'(strobes), 32'(s0 + 1));
    valid_in = 1'b0;
    repeat (6) tick();

    // Rounding half-up and half-down.
    window4(12'h800, 12'h800, 12'h801, 12'h801);
    window4(12'h800, 12'h800, 12'h800, 12'h801);

    // Lock acquisition and loss; win_count saturates at 7.
    window4(12'h805, 12'h805, 12'h805, 12'h805);
    window4(12'h806, 12'h806, 12'h806, 12'h806);
    window4(12'h805, 12'h805, 12'h805, 12'h805);
    window4(12'h805, 12'h805, 12'h805, 12'h805);
    chk("locked_held", 32'(locked), 32'h1);
    window4(12'h808, 12'h808, 12'h808, 12'h808);

    // A long valid level captures once.
    s0 = strobes;
    set_code(12'h100);
    valid_in = 1'b1;
    repeat (10) tick();
    valid_in = 1'b0;
    repeat (6) tick();
    pulse(12'h200);
    chk("no_strobe_two_samples", 32'(strobes), 32'(s0));
    expect_window('h100 + 'h200 + 'h300 + 'h300);
    pulse(12'h300);
    pulse(12'h300);
    chk("strobe_after_four", 32'(strobes), 32'(s0 + 1));

    // pwrup drop mid-window discards the partial window.
    pulse(12'h555);
    pulse(12'h555);
    pwrup = 1'b0;
    tick();
    check_cleared("pwrdn2");
    model_clear();
    pwrup = 1'b1;
    tick();
    window4(12'h123, 12'h123, 12'h123, 12'h123);

    // Async reset mid-window behaves the same way.
    pulse(12'h555);
    pulse(12'h555);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check_cleared("async_rst");
    @(negedge clk);
    reset_n = 1'b1;
    model_clear();
    tick();
    window4(12'h123, 12'h123, 12'h123, 12'h123);

    repeat (4) tick();
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
